// File: rtl/usb_bulk_sched.sv
// usb_bulk_sched: bulk IN/OUT transfer scheduler owning the shared USB<->SD data FIFO
// Ports: clk, n_rst (async active-low); pid_valid/pid and rx_eop/crc_ok from the packet decoder;
// fifo_count in, fifo_dir/fifo_clear out for the shared FIFO; sd_tx_en_write/write_done and
// sd_rx_en_read/read_done SD block requests; tx_start/tx_pid/tx_done to the packet encoder;
// in_ready (IN block staged), busy, xfer_err (CRC error, short packet or ACK timeout).
module usb_bulk_sched #(
  parameter int BLOCK_BYTES = 64,
  parameter int ACK_TIMEOUT = 144
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       pid_valid,
  input  logic [3:0] pid,
  input  logic       rx_eop,
  input  logic       crc_ok,
  input  logic [6:0] fifo_count,
  output logic       fifo_dir,
  output logic       fifo_clear,
  output logic       sd_tx_en_write,
  input  logic       write_done,
  output logic       sd_rx_en_read,
  input  logic       read_done,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  input  logic       tx_done,
  output logic       in_ready,
  output logic       busy,
  output logic       xfer_err
);
  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_D0  = 4'b0011;
  localparam logic [3:0] PID_D1  = 4'b1011;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] OUT_RX      = 3'd1;
  localparam logic [2:0] OUT_HS      = 3'd2;
  localparam logic [2:0] SD_WR       = 3'd3;
  localparam logic [2:0] IN_TX       = 3'd4;
  localparam logic [2:0] IN_WAIT_ACK = 3'd5;
  localparam logic [2:0] NAK_TX      = 3'd6;
  localparam int CW = $clog2(ACK_TIMEOUT);
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic out_toggle, in_toggle, data_seen, data_pid1, hs_wr;
  logic pv, known, is_data, is_token, sd_busy, cnt_exp;
  // end of packet takes precedence over a coincident PID strobe
  assign pv = pid_valid && !rx_eop;
  assign known = pid inside {PID_OUT, PID_IN, PID_D0, PID_D1, PID_ACK, PID_NAK};
  assign is_data = pid == PID_D0 || pid == PID_D1;
  assign is_token = pid == PID_OUT || pid == PID_IN;
  assign sd_busy = sd_tx_en_write || sd_rx_en_read;
  assign cnt_exp = cnt == CW'(ACK_TIMEOUT - 1);
  assign busy = state != IDLE || sd_busy;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      out_toggle <= 1'b0;
      in_toggle <= 1'b0;
      data_seen <= 1'b0;
      data_pid1 <= 1'b0;
      hs_wr <= 1'b0;
      fifo_dir <= 1'b0;
      fifo_clear <= 1'b0;
      sd_tx_en_write <= 1'b0;
      sd_rx_en_read <= 1'b0;
      tx_start <= 1'b0;
      tx_pid <= 4'b0000;
      in_ready <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      fifo_clear <= 1'b0;
      xfer_err <= 1'b0;
      // SD requests finish in the background, whatever the token state machine is doing
      if (write_done && sd_tx_en_write) begin
        sd_tx_en_write <= 1'b0;
        fifo_clear <= 1'b1;
      end
      if (read_done && sd_rx_en_read) begin
        sd_rx_en_read <= 1'b0;
        in_ready <= 1'b1;
      end
      case (state)
        IDLE:
          if (pv && pid == PID_OUT) begin
            if (fifo_count == 7'd0 && !in_ready && !sd_busy) begin
              fifo_dir <= 1'b0;
              data_seen <= 1'b0;
              state <= OUT_RX;
            end else begin
              tx_start <= 1'b1;
              tx_pid <= PID_NAK;
              state <= NAK_TX;
            end
          end else if (pv && pid == PID_IN) begin
            tx_start <= 1'b1;
            if (in_ready) begin
              tx_pid <= in_toggle ? PID_D1 : PID_D0;
              state <= IN_TX;
            end else begin
              tx_pid <= PID_NAK;
              state <= NAK_TX;
              if (!sd_busy && fifo_count == 7'd0) begin
                fifo_dir <= 1'b1;
                sd_rx_en_read <= 1'b1;
              end
            end
          end
        OUT_RX:
          if (rx_eop && data_seen) begin
            if (!crc_ok || fifo_count != 7'(BLOCK_BYTES)) begin
              fifo_clear <= 1'b1;
              xfer_err <= 1'b1;
              state <= IDLE;
            end else begin
              tx_start <= 1'b1;
              tx_pid <= PID_ACK;
              state <= OUT_HS;
              hs_wr <= data_pid1 == out_toggle;
              // a retransmitted block is acknowledged but discarded
              if (data_pid1 == out_toggle) out_toggle <= ~out_toggle;
              else fifo_clear <= 1'b1;
            end
          end else if (pv && is_data) begin
            data_seen <= 1'b1;
            data_pid1 <= pid[3];
          end
        OUT_HS:
          if (tx_done) begin
            sd_tx_en_write <= hs_wr;
            state <= hs_wr ? SD_WR : IDLE;
          end
        SD_WR:
          if (pv && is_token) begin
            tx_start <= 1'b1;
            tx_pid <= PID_NAK;
            state <= NAK_TX;
          end else if (write_done) state <= IDLE;
        IN_TX:
          if (tx_done) begin
            cnt <= '0;
            state <= IN_WAIT_ACK;
          end
        IN_WAIT_ACK:
          if (pv && pid == PID_ACK) begin
            in_toggle <= ~in_toggle;
            in_ready <= 1'b0;
            fifo_clear <= 1'b1;
            state <= IDLE;
          end else if ((pv && known) || cnt_exp) begin
            // block and toggle are kept; fifo_dir stays 1 so TX re-reads the block
            xfer_err <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        NAK_TX:
          if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
